// File: rtl/mbit_hs_rx.sv
// mbit_hs_rx: destination-side end of a four-phase req/ack multi-bit CDC.
// The request level is synchronized into clkb. The data word is sampled
// directly because the source holds it stable while req_in is high. The
// captured word is presented on a one-entry valid/ready output buffer.
//
// Optional build macro: MBIT_HS_RX_PARITY_EN. When it is defined, the block
// adds par_in and a sticky par_err flag. When it is undefined, the block has
// no parity ports and no parity logic.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ack_out low; capture once req_s is high and the buffer is free
// ACK   | ack_out high; wait for req_s to drop, then release the source
module mbit_hs_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clkb,
  input  logic                  rst_n,
  input  logic                  req_in,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef MBIT_HS_RX_PARITY_EN
  input  logic                  par_in,
  output logic                  par_err,
`endif
  output logic                  ack_out,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   free;

  assign req_s = sync_q[SYNC_STAGES-1];
  // A word can be captured when the buffer is empty or is being drained on this edge.
  assign free  = !dout_valid || dout_ready;

  // Shift the asynchronous request level through the synchronizer chain.
  always_ff @(posedge clkb) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end
  end

  // Run the handshake FSM and the output buffer. The consumer drains the buffer first, and a capture on the same edge overrides that drain.
  always_ff @(posedge clkb) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack_out    <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
`ifdef MBIT_HS_RX_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (req_s && free) begin
            dout       <= data_in;
            dout_valid <= 1'b1;
            ack_out    <= 1'b1;
            state      <= ACK;
`ifdef MBIT_HS_RX_PARITY_EN
            if (^{data_in, par_in}) begin
              par_err <= 1'b1;
            end
`endif
          end
        end
        ACK: begin
          if (!req_s) begin
            ack_out <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          ack_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbit_hs_rx.sv
// Testbench for mbit_hs_rx, which is built with DATA_WIDTH=8 and SYNC_STAGES=2.
// Expected words go into a queue when each request is issued. A monitor
// process pops that queue and compares against dout on every accepted word.
module tb_mbit_hs_rx;

  logic       clkb = 1'b0;
  logic       rst_n;
  logic       req_in;
  logic [7:0] data_in;
  logic       ack_out;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
`ifdef MBIT_HS_RX_PARITY_EN
  logic       par_in;
  logic       par_err;
`endif

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  mbit_hs_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clkb       (clkb),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .data_in    (data_in),
`ifdef MBIT_HS_RX_PARITY_EN
    .par_in     (par_in),
    .par_err    (par_err),
`endif
    .ack_out    (ack_out),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clkb = ~clkb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkb);
      #1;
    end
  endtask

  // Wait, within a bounded number of cycles, for ack_out to reach the given level.
  task automatic wait_ack(input logic level);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ack_out == level) break;
    end
    check("ack_wait", {31'd0, ack_out}, {31'd0, level});
  endtask

  task automatic send(input logic [7:0] d);
    data_in = d;
    req_in  = 1'b1;
    exp_q.push_back(d);
    wait_ack(1'b1);
    req_in  = 1'b0;
    wait_ack(1'b0);
  endtask

  // On each cycle where the consumer accepts a word, compare dout with the next expected word.
  initial begin
    forever begin
      @(negedge clkb);
      if (rst_n && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept", {24'd0, dout}, 32'hFFFF_FFFF);
        end else begin
          check("accept_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    req_in     = 1'b0;
    data_in    = 8'h00;
    dout_ready = 1'b0;
`ifdef MBIT_HS_RX_PARITY_EN
    par_in     = 1'b0;
`endif
    tick(3);
    check("rst_ack", {31'd0, ack_out}, 32'd0);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single transfer: check the cycle-exact timing of capture and ack.
    dout_ready = 1'b1;
    data_in    = 8'hA5;
    req_in     = 1'b1;
    exp_q.push_back(8'hA5);
    tick(1);
    check("t1_ack_k", {31'd0, ack_out}, 32'd0);
    tick(1);
    check("t1_valid_k1", {31'd0, dout_valid}, 32'd0);
    tick(1);
    check("t1_ack_k2", {31'd0, ack_out}, 32'd1);
    check("t1_valid_k2", {31'd0, dout_valid}, 32'd1);
    check("t1_dout_k2", {24'd0, dout}, 32'hA5);
    tick(1);
    check("t1_valid_k3", {31'd0, dout_valid}, 32'd0);
    check("t1_ack_k3", {31'd0, ack_out}, 32'd1);
    req_in = 1'b0;
    tick(1);
    check("t1_ack_m", {31'd0, ack_out}, 32'd1);
    tick(1);
    check("t1_ack_m1", {31'd0, ack_out}, 32'd1);
    tick(1);
    check("t1_ack_m2", {31'd0, ack_out}, 32'd0);
    tick(3);

    // Backpressure: hold 8'h11 in the buffer while 8'h22 is requested.
    dout_ready = 1'b0;
    send(8'h11);
    data_in = 8'h22;
    req_in  = 1'b1;
    exp_q.push_back(8'h22);
    tick(6);
    check("bp_ack_low", {31'd0, ack_out}, 32'd0);
    check("bp_dout_held", {24'd0, dout}, 32'h11);
    check("bp_valid_held", {31'd0, dout_valid}, 32'd1);
    dout_ready = 1'b1;
    tick(1);
    check("bp_valid_nogap", {31'd0, dout_valid}, 32'd1);
    check("bp_dout_new", {24'd0, dout}, 32'h22);
    check("bp_ack_rise", {31'd0, ack_out}, 32'd1);
    req_in = 1'b0;
    wait_ack(1'b0);
    tick(2);

    // Send four words back to back.
    for (int i = 1; i <= 4; i++) begin
      send(8'(i));
    end
    tick(3);
    check("burst_drained", exp_q.size(), 32'd0);

    // Assert reset while the FSM is in ACK.
    dout_ready = 1'b0;
    data_in    = 8'h55;
    req_in     = 1'b1;
    wait_ack(1'b1);
    rst_n  = 1'b0;
    req_in = 1'b0;
    tick(1);
    check("mid_rst_ack", {31'd0, ack_out}, 32'd0);
    check("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    check("mid_rst_dout", {24'd0, dout}, 32'd0);
    tick(1);
    rst_n      = 1'b1;
    dout_ready = 1'b1;
    tick(8);
    check("post_rst_valid", {31'd0, dout_valid}, 32'd0);
    check("post_rst_ack", {31'd0, ack_out}, 32'd0);

`ifdef MBIT_HS_RX_PARITY_EN
    // Parity error flag: clear on a good word, set on a bad one, stay set until reset.
    par_in = 1'b0;
    send(8'h03);
    check("par_good", {31'd0, par_err}, 32'd0);
    data_in = 8'h07;
    req_in  = 1'b1;
    exp_q.push_back(8'h07);
    wait_ack(1'b1);
    check("par_bad_edge", {31'd0, par_err}, 32'd1);
    req_in = 1'b0;
    wait_ack(1'b0);
    send(8'h03);
    check("par_sticky", {31'd0, par_err}, 32'd1);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("par_rst", {31'd0, par_err}, 32'd0);
    rst_n = 1'b1;
    tick(2);
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
